// File: rtl/w5500_spi_responder.sv
// W5500-compatible SPI responder: decodes address/control/data frames from an
// oversampled mode-0 SPI bus and serves them from a byte-wide memory port
// addressed by {BSB, address}. Used as an in-FPGA loopback target for the
// W5500 SPI master and the command/packet logic above it.
module w5500_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk_50m,
    input  logic        i_rst,
    input  logic        i_spi_cs,
    input  logic        i_spi_dclk,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic        o_spi_miso_oe,
    output logic        o_mem_wren,
    output logic        o_mem_rden,
    output logic [20:0] o_mem_addr,
    output logic [7:0]  o_mem_wrdata,
    input  logic [7:0]  i_mem_rddata,
    output logic        o_frame_done,
    output logic        o_frame_abort,
    output logic        o_frame_rwb,
    output logic [4:0]  o_frame_bsb,
    output logic [15:0] o_frame_len
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_CTRL = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                 state_r;

    // Synchronizer chains and their outputs
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   mosi_s;

    // Edge detection on the synchronized SPI signals
    logic                   cs_prev_r;
    logic                   sclk_prev_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   mosi_bit_r;

    // Frame bookkeeping
    logic [3:0]             bit_cnt_r;
    logic [15:0]            addr_r;
    logic [7:0]             shift_in_r;
    logic [4:0]             bsb_r;
    logic                   rwb_r;
    logic                   vdm_r;
    logic [2:0]             rem_r;

    // Read path: fetched byte buffer and MISO shifter
    logic [7:0]             rd_buf_r;
    logic [7:0]             miso_shift_r;
    logic                   load_pending_r;
    logic                   rden_d_r;

    // Derived per-rise values
    logic [7:0]             byte_s;
    logic [15:0]            addr_inc_s;
    logic                   last_byte_s;
    logic [2:0]             rem_init_s;

    assign cs_s   = cs_sync_r[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    // Bring the asynchronous SPI pins into the system clock domain.
    // CS resets low so a chip select already asserted at reset release is
    // not mistaken for a fresh falling edge.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            cs_sync_r   <= {SYNC_STAGES{1'b0}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], i_spi_cs};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], i_spi_dclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_spi_mosi};
        end
    end

    // Register SCLK rise/fall pulses and the MOSI bit that goes with a rise.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            cs_prev_r   <= 1'b0;
            sclk_prev_r <= 1'b0;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
            mosi_bit_r  <= 1'b0;
        end else begin
            cs_prev_r   <= cs_s;
            sclk_prev_r <= sclk_s;
            rise_r      <= sclk_s & ~sclk_prev_r;
            fall_r      <= ~sclk_s & sclk_prev_r;
            mosi_bit_r  <= mosi_s;
        end
    end

    // Assemble the byte completed by this rise and derive byte-boundary values.
    always_comb begin
        byte_s      = {shift_in_r[6:0], mosi_bit_r};
        addr_inc_s  = addr_r + 16'd1;
        last_byte_s = ~vdm_r & (rem_r == 3'd1);
        case (byte_s[1:0])
            2'b01:   rem_init_s = 3'd1;
            2'b10:   rem_init_s = 3'd2;
            2'b11:   rem_init_s = 3'd4;
            default: rem_init_s = 3'd0;
        endcase
    end

    // Frame state machine with all memory, MISO and frame-status outputs.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state_r        <= ST_IDLE;
            bit_cnt_r      <= 4'd0;
            addr_r         <= 16'd0;
            shift_in_r     <= 8'd0;
            bsb_r          <= 5'd0;
            rwb_r          <= 1'b0;
            vdm_r          <= 1'b0;
            rem_r          <= 3'd0;
            rd_buf_r       <= 8'd0;
            miso_shift_r   <= 8'd0;
            load_pending_r <= 1'b0;
            rden_d_r       <= 1'b0;
            o_spi_miso     <= 1'b0;
            o_spi_miso_oe  <= 1'b0;
            o_mem_wren     <= 1'b0;
            o_mem_rden     <= 1'b0;
            o_mem_addr     <= 21'd0;
            o_mem_wrdata   <= 8'd0;
            o_frame_done   <= 1'b0;
            o_frame_abort  <= 1'b0;
            o_frame_rwb    <= 1'b0;
            o_frame_bsb    <= 5'd0;
            o_frame_len    <= 16'd0;
        end else begin
            o_mem_wren    <= 1'b0;
            o_mem_rden    <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_abort <= 1'b0;
            o_spi_miso_oe <= ~cs_s;
            rden_d_r      <= o_mem_rden;
            // Read data is valid the cycle after the strobe; capture it then.
            if (rden_d_r) begin
                rd_buf_r <= i_mem_rddata;
            end

            if (cs_s) begin
                // CS high ends any frame; a pending SCLK edge is dropped.
                state_r    <= ST_IDLE;
                o_spi_miso <= 1'b0;
                case (state_r)
                    ST_DATA, ST_DONE: begin
                        o_frame_done <= 1'b1;
                        o_frame_rwb  <= rwb_r;
                        o_frame_bsb  <= bsb_r;
                    end
                    ST_ADDR, ST_CTRL: begin
                        o_frame_abort <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        o_spi_miso <= 1'b0;
                        if (cs_prev_r) begin
                            state_r        <= ST_ADDR;
                            bit_cnt_r      <= 4'd0;
                            addr_r         <= 16'd0;
                            shift_in_r     <= 8'd0;
                            miso_shift_r   <= 8'd0;
                            load_pending_r <= 1'b0;
                            o_frame_len    <= 16'd0;
                        end
                    end
                    ST_ADDR: begin
                        if (rise_r) begin
                            addr_r <= {addr_r[14:0], mosi_bit_r};
                            if (bit_cnt_r == 4'd15) begin
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_CTRL;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_CTRL: begin
                        if (rise_r) begin
                            shift_in_r <= byte_s;
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r <= 4'd0;
                                bsb_r     <= byte_s[7:3];
                                rwb_r     <= byte_s[2];
                                vdm_r     <= (byte_s[1:0] == 2'b00);
                                rem_r     <= rem_init_s;
                                state_r   <= ST_DATA;
                                // Reads fetch the first byte as soon as the control byte is known.
                                if (!byte_s[2]) begin
                                    o_mem_rden     <= 1'b1;
                                    o_mem_addr     <= {byte_s[7:3], addr_r};
                                    load_pending_r <= 1'b1;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rise_r) begin
                            shift_in_r <= byte_s;
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r   <= 4'd0;
                                addr_r      <= addr_inc_s;
                                o_frame_len <= o_frame_len + 16'd1;
                                if (!vdm_r) begin
                                    rem_r <= rem_r - 3'd1;
                                end
                                if (rwb_r) begin
                                    o_mem_wren   <= 1'b1;
                                    o_mem_addr   <= {bsb_r, addr_r};
                                    o_mem_wrdata <= byte_s;
                                end else if (!last_byte_s) begin
                                    // Prefetch the byte that will be shifted out next.
                                    o_mem_rden     <= 1'b1;
                                    o_mem_addr     <= {bsb_r, addr_inc_s};
                                    load_pending_r <= 1'b1;
                                end
                                if (last_byte_s) begin
                                    state_r    <= ST_DONE;
                                    o_spi_miso <= 1'b0;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end else if (fall_r && !rwb_r) begin
                            if (load_pending_r) begin
                                miso_shift_r   <= rd_buf_r;
                                o_spi_miso     <= rd_buf_r[7];
                                load_pending_r <= 1'b0;
                            end else begin
                                miso_shift_r <= {miso_shift_r[6:0], 1'b0};
                                o_spi_miso   <= miso_shift_r[6];
                            end
                        end
                    end
                    ST_DONE: begin
                        o_spi_miso <= 1'b0;
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        o_spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_w5500_spi_responder.sv
// Self-checking bench for w5500_spi_responder: directed test-plan frames plus
// randomized frames, checked against a frame-level reference model.
module tb_w5500_spi_responder;

    localparam int S  = 2;
    localparam int H  = 2 * S + 6;   // SCLK half period in system clocks
    localparam int LAT = S + 2;      // pin edge to strobe latency

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic        mem_wren;
    logic        mem_rden;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wrdata;
    logic [7:0]  mem_rddata = 8'h00;
    logic        frame_done;
    logic        frame_abort;
    logic        frame_rwb;
    logic [4:0]  frame_bsb;
    logic [15:0] frame_len;

    w5500_spi_responder #(.SYNC_STAGES(S)) dut (
        .i_clk_50m     (clk),
        .i_rst         (rst),
        .i_spi_cs      (cs),
        .i_spi_dclk    (sclk),
        .i_spi_mosi    (mosi),
        .o_spi_miso    (miso),
        .o_spi_miso_oe (miso_oe),
        .o_mem_wren    (mem_wren),
        .o_mem_rden    (mem_rden),
        .o_mem_addr    (mem_addr),
        .o_mem_wrdata  (mem_wrdata),
        .i_mem_rddata  (mem_rddata),
        .o_frame_done  (frame_done),
        .o_frame_abort (frame_abort),
        .o_frame_rwb   (frame_rwb),
        .o_frame_bsb   (frame_bsb),
        .o_frame_len   (frame_len)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    bit   [7:0]  mem     [2**21];   // memory the DUT talks to
    bit   [7:0]  ref_mem [2**21];   // reference contents kept by the model
    logic [28:0] wr_q [$];
    logic [20:0] rd_q [$];
    int          lat_q [$];
    logic [7:0]  tx_data [16];
    logic        prev_rwb = 1'b0;
    logic [4:0]  prev_bsb = 5'd0;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // byte-wide memory: registered read, data valid the cycle after the strobe
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wrdata;
        if (mem_rden) mem_rddata <= mem[mem_addr];
    end

    // record strobes and frame pulses away from the active edge
    always @(negedge clk) begin
        if (mem_wren) begin
            wr_q.push_back({mem_addr, mem_wrdata});
            lat_q.push_back(cyc - last_rise_cyc);
        end
        if (mem_rden) begin
            rd_q.push_back(mem_addr);
            lat_q.push_back(cyc - last_rise_cyc);
        end
        if (frame_done)  done_cnt  = done_cnt + 1;
        if (frame_abort) abort_cnt = abort_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        @(posedge clk);
        wr_q.delete();
        rd_q.delete();
        lat_q.delete();
        done_cnt  = 0;
        abort_cnt = 0;
    endtask

    // Shift nbits of tx (MSB first) in mode 0; rx holds MISO sampled at each rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            repeat (H) @(negedge clk);
            rx[i] = miso;
            last_rise_cyc = cyc;
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic check_latency(input string tag);
        for (int k = 0; k < lat_q.size(); k++) check({tag, "_lat"}, lat_q[k], LAT);
    endtask

    // Run one complete frame and compare against the frame-level model.
    task automatic run_frame(input logic [15:0] addr, input logic [7:0] ctrl,
                             input int nbytes, input int extra_bits, input string tag);
        logic [7:0]  rx [16];
        logic [7:0]  d;
        logic [4:0]  bsb;
        logic        rwb;
        int          lim;
        int          neff;
        int          nrd;
        logic [15:0] a;
        logic [7:0]  ev;
        bsb = ctrl[7:3];
        rwb = ctrl[2];
        case (ctrl[1:0])
            2'b01:   lim = 1;
            2'b10:   lim = 2;
            2'b11:   lim = 4;
            default: lim = 1000;
        endcase
        neff = (nbytes < lim) ? nbytes : lim;
        clear_obs();
        @(negedge clk);
        cs = 1'b0;
        xfer(addr[15:8], 8, d);
        xfer(addr[7:0], 8, d);
        xfer(ctrl, 8, d);
        for (int k = 0; k < nbytes; k++) xfer(tx_data[k], 8, rx[k]);
        if (extra_bits > 0) xfer(tx_data[nbytes], extra_bits, d);
        repeat (H) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);

        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_abort"}, abort_cnt, 0);
        check({tag, "_len"}, frame_len, neff);
        check({tag, "_rwb"}, frame_rwb, rwb);
        check({tag, "_bsb"}, frame_bsb, bsb);
        if (rwb) begin
            check({tag, "_wr_n"}, wr_q.size(), neff);
            check({tag, "_rd_n"}, rd_q.size(), 0);
            for (int k = 0; k < neff; k++) begin
                a = addr + 16'(k);
                if (k < wr_q.size()) check({tag, "_wr"}, wr_q[k], {bsb, a, tx_data[k]});
                ref_mem[{bsb, a}] = tx_data[k];
            end
            for (int k = 0; k < nbytes; k++) check({tag, "_miso0"}, rx[k], 8'h00);
        end else begin
            nrd = (neff == lim) ? neff : neff + 1;
            check({tag, "_rd_n"}, rd_q.size(), nrd);
            check({tag, "_wr_n"}, wr_q.size(), 0);
            for (int k = 0; k < nrd; k++) begin
                a = addr + 16'(k);
                if (k < rd_q.size()) check({tag, "_rd"}, rd_q[k], {bsb, a});
            end
            for (int k = 0; k < nbytes; k++) begin
                a  = addr + 16'(k);
                ev = (k < neff) ? ref_mem[{bsb, a}] : 8'h00;
                check({tag, "_rx"}, rx[k], ev);
            end
        end
        check_latency(tag);
        prev_rwb = rwb;
        prev_bsb = bsb;
    endtask

    // CS rises after only nbits of the address phase.
    task automatic run_abort(input logic [15:0] addr, input int nbits, input string tag);
        logic [7:0] d;
        clear_obs();
        @(negedge clk);
        cs = 1'b0;
        if (nbits > 8) begin
            xfer(addr[15:8], 8, d);
            xfer(addr[7:0], nbits - 8, d);
        end else begin
            xfer(addr[15:8], nbits, d);
        end
        repeat (H) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check({tag, "_abort"}, abort_cnt, 1);
        check({tag, "_done"}, done_cnt, 0);
        check({tag, "_wr_n"}, wr_q.size(), 0);
        check({tag, "_rd_n"}, rd_q.size(), 0);
        check({tag, "_rwb"}, frame_rwb, prev_rwb);
        check({tag, "_bsb"}, frame_bsb, prev_bsb);
    endtask

    initial begin
        logic [7:0]  d;
        logic [7:0]  rx;
        logic [15:0] ra;
        logic [7:0]  rc;
        logic [7:0]  v;
        int          nb;
        int          xb;

        rst  = 1'b1;
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_miso", miso, 1'b0);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_wren", mem_wren, 1'b0);
        check("rst_rden", mem_rden, 1'b0);
        check("rst_addr", mem_addr, 21'd0);
        check("rst_wrdata", mem_wrdata, 8'd0);
        check("rst_done", frame_done, 1'b0);
        check("rst_abort", frame_abort, 1'b0);
        check("rst_rwb", frame_rwb, 1'b0);
        check("rst_bsb", frame_bsb, 5'd0);
        check("rst_len", frame_len, 16'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // VDM write of three bytes
        tx_data[0] = 8'hA5; tx_data[1] = 8'h5A; tx_data[2] = 8'h3C;
        run_frame(16'h0010, 8'h0C, 3, 0, "vdm_wr");

        // VDM read of two preloaded bytes
        mem[{5'd2, 16'h0100}] = 8'h11; ref_mem[{5'd2, 16'h0100}] = 8'h11;
        mem[{5'd2, 16'h0101}] = 8'h22; ref_mem[{5'd2, 16'h0101}] = 8'h22;
        run_frame(16'h0100, 8'h10, 2, 0, "vdm_rd");

        // FDM 2-byte write while master clocks four bytes
        for (int k = 0; k < 4; k++) tx_data[k] = 8'($urandom);
        run_frame(16'h0200, 8'h06, 4, 0, "fdm_wr");

        // Abort in the address phase, then a clean frame
        run_abort(16'h1234, 10, "abort_addr");
        for (int k = 0; k < 2; k++) tx_data[k] = 8'($urandom);
        run_frame(16'h0300, 8'h0C, 2, 0, "after_abort");

        // CS rise after five bits of the second data byte
        for (int k = 0; k < 2; k++) tx_data[k] = 8'($urandom);
        run_frame(16'h0400, 8'h0C, 1, 5, "abort_data");

        // Address wrap at 0xFFFF
        tx_data[0] = 8'hC3; tx_data[1] = 8'h96;
        run_frame(16'hFFFF, 8'h1C, 2, 0, "wrap");

        // Reset in the middle of a read frame
        clear_obs();
        @(negedge clk);
        cs = 1'b0;
        xfer(8'h01, 8, d);
        xfer(8'h00, 8, d);
        xfer(8'h10, 8, d);
        xfer(8'hFF, 3, d);
        repeat (H) @(negedge clk);
        check("pre_rst_miso", miso, ref_mem[{5'd2, 16'h0100}][4]);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_miso", miso, 1'b0);
        check("mid_rst_oe", miso_oe, 1'b0);
        check("mid_rst_rden", mem_rden, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_obs();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            xfer(8'($urandom), 8, rx);
            check("post_rst_miso", rx, 8'h00);
        end
        repeat (H) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_wr_n", wr_q.size(), 0);
        check("post_rst_rd_n", rd_q.size(), 0);
        check("post_rst_done", done_cnt, 0);
        check("post_rst_abort", abort_cnt, 0);
        check("post_rst_len", frame_len, 16'd0);
        prev_rwb = 1'b0;
        prev_bsb = 5'd0;

        // Next frame after reset reads back the wrapped write
        run_frame(16'hFFFF, 8'h18, 2, 0, "post_rst_rd");

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
            rc = 8'($urandom);
            nb = $urandom_range(0, 5);
            xb = $urandom_range(0, 7);
            for (int k = 0; k < 16; k++) tx_data[k] = 8'($urandom);
            if (!rc[2]) begin
                for (int k = 0; k < 8; k++) begin
                    v = 8'($urandom);
                    mem[{rc[7:3], ra + 16'(k)}]     = v;
                    ref_mem[{rc[7:3], ra + 16'(k)}] = v;
                end
            end
            run_frame(ra, rc, nb, xb, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/w5500_spi_responder.md
# w5500_spi_responder

- Synthesizable SPI slave that implements the responder side of the W5500 SPI frame protocol: 16-bit address, 8-bit control, then data.
- It serves reads and writes from a byte-wide memory port keyed by {BSB, address}.
- It sits beside the Ethernet control path as a loopback target, so the W5500 SPI master and the command/packet logic can be exercised in-FPGA and in simulation without the physical chip.
- All logic runs on the system clock; SPI pins are oversampled.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for the CS, SCLK and MOSI inputs (minimum 2).

Ports:
- i_clk_50m  in  1  system clock. One clock; reset is synchronous and active-high.
- i_rst  in  1  synchronous active-high reset.
- i_spi_cs  in  1  chip select, active low.
- i_spi_dclk  in  1  SPI clock, mode 0.
- i_spi_mosi  in  1  master-out data, MSB first.
- o_spi_miso  out  1  slave-out data.
- o_spi_miso_oe  out  1  high while CS is asserted (synced).
- o_mem_wren  out  1  one-cycle write strobe.
- o_mem_rden  out  1  one-cycle read strobe.
- o_mem_addr  out  21  {BSB[4:0], addr[15:0]}.
- o_mem_wrdata  out  8  write byte.
- i_mem_rddata  in  8  read byte; valid exactly 1 cycle after o_mem_rden.
- o_frame_done  out  1  one-cycle pulse when CS deasserts after a complete control phase.
- o_frame_abort  out  1  one-cycle pulse when CS deasserts before the control phase completes.
- o_frame_rwb  out  1  RWB bit of the last frame (1 = write).
- o_frame_bsb  out  5  BSB of the last frame.
- o_frame_len  out  16  number of complete data bytes transferred in the last frame.

## Operation
- Inputs pass through SYNC_STAGES flops. Edge detection on synced SCLK produces rise/fall pulses one cycle later.
- Sampling: MOSI is sampled on SCLK rise. MISO is updated on SCLK fall. Mode 0 only.
- Synced CS high forces state IDLE, regardless of the current state.
- States:
  - IDLE: on CS falling, go to ADDR. Clear the bit counter, byte counter and shift registers.
  - ADDR: 16 rises shift addr[15:0], MSB first, then go to CTRL.
  - CTRL: 8 rises shift the control byte.
    - Fields: BSB = ctrl[7:3], RWB = ctrl[2], OM = ctrl[1:0].
    - Remaining byte count: OM=00 (VDM) unlimited; 01 → 1; 10 → 2; 11 → 4.
    - On the 8th rise, go to DATA. If RWB=0, pulse o_mem_rden with the current address.
  - DATA, write: every 8th rise pulses o_mem_wren with the assembled byte at the current address.
  - DATA, read:
    - On the 8th rise of each byte, pulse o_mem_rden for the next address.
    - The fetched byte is loaded into the MISO shift register at the next SCLK fall, and its MSB is driven then.
    - Each later fall shifts left.
  - After each completed byte: address increments (16-bit, 0xFFFF wraps to 0x0000; BSB unchanged) and o_frame_len increments.
  - FDM: when the remaining count reaches 0, go to DONE.
  - DONE: ignore SCLK, o_spi_miso = 0, no memory strobes, until CS rises.
- CS rise:
  - A partial byte is discarded: no write, and o_frame_len is not incremented.
  - If the state was DATA or DONE (control phase complete): pulse o_frame_done. o_frame_rwb and o_frame_bsb are latched from the control byte and stay held until the next frame.
  - Otherwise (state ADDR or CTRL): pulse o_frame_abort.
- o_spi_miso is 0 in IDLE, ADDR, CTRL and DONE, and during write frames.
- o_spi_miso_oe = synced CS low.

## Timing
- Reset values: o_spi_miso 0, o_spi_miso_oe 0, all strobes and pulses 0, o_mem_addr 0, o_mem_wrdata 0, o_frame_rwb 0, o_frame_bsb 0, o_frame_len 0, state IDLE.
- Reset mid-frame: the block returns to IDLE within one cycle. It stays in IDLE until it sees a fresh CS high→low edge after reset is released; a frame already in progress is ignored.
- Write strobe: o_mem_wren is asserted exactly 1 cycle after the internal rise pulse of the byte's last bit, i.e. SYNC_STAGES+2 clocks after the pin edge.
- Read strobe: o_mem_rden follows the same timing. i_mem_rddata is captured the following cycle.
- MISO output: o_spi_miso changes SYNC_STAGES+2 clocks after the SCLK falling pin edge.
- Requirement: SCLK high and low time ≥ 2·SYNC_STAGES+4 clocks each. This guarantees:
  - the read data is fetched before its fall edge;
  - MISO settles before the master's sampling rise.
- A simultaneous SCLK edge and CS rise: CS wins, and the edge is ignored.
- o_frame_done and o_frame_abort are asserted 1 cycle after the synced CS rise is detected.

## Test plan
- VDM write: addr 0x0010, ctrl 0x0C (BSB 1, RWB 1, OM 00), data 0xA5 0x5A 0x3C, CS rise → three wren at {1,0x0010..0x0012} with those bytes; frame_done with len 3, rwb 1, bsb 1.
- VDM read: memory preloaded with {2,0x0100}=0x11, 0x0101=0x22; ctrl 0x10 (BSB 2, read), clock 16 data bits → MISO returns 0x11 then 0x22; rden at 0x0100 and 0x0101, plus one prefetch at 0x0102; len 2.
- FDM 2-byte write (ctrl 0x06), then master clocks 4 bytes → only 2 wren; MISO stays 0 in DONE; len 2.
- Abort: CS rises after 10 address bits → frame_abort pulse, no strobes; the next frame is fully correct. CS rise after 5 data bits → no partial write, len reflects whole bytes only.
- Wrap: VDM write at 0xFFFF with 2 bytes → writes at 0xFFFF then 0x0000, same BSB.
- Reset mid-frame: assert i_rst during DATA of a read → MISO/oe 0 next cycle and no strobes; after release with CS still low, SCLK activity is ignored; the next CS frame works.
